// File: rtl/infifo_load_ctrl.sv
// Input-FIFO unload sequencer: sweeps FIFO read addresses per codeword and
// forwards each read word, address-tagged, into the decoder LLR memory.
module infifo_load_ctrl #(
    parameter int W            = 6,
    parameter int ADDRESSWIDTH = 5,
    parameter int NB           = 16,
    parameter int DW           = 32 * W,
    parameter int LOADDEPTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_fsm_start,
    input  logic                    dec_ready,
    input  logic [NB*DW-1:0]        DOUT_nb,
    output logic [ADDRESSWIDTH-1:0] RA,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] llr_wa,
    output logic [NB*DW-1:0]        llr_wd,
    output logic                    llr_we,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    start_err
);

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR  = ADDRESSWIDTH'(LOADDEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] DRAIN_LAST = ADDRESSWIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DEC,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDRESSWIDTH-1:0] count;
    logic [ADDRESSWIDTH-1:0] count_nxt;
    logic                    pending;
    logic                    pending_nxt;
    logic                    err_nxt;
    logic                    accept;
    logic                    s1_vld;
    logic [ADDRESSWIDTH-1:0] s1_ra;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        pending_nxt = pending;
        err_nxt     = start_err;
        rd_en       = 1'b0;
        RA          = '0;
        load_busy   = (state != IDLE);
        load_done   = 1'b0;
        accept      = load_fsm_start && !pending &&
                      ((state == IDLE) || (state == WAIT_DEC));

        if (load_fsm_start && !accept) begin
            err_nxt = 1'b1;
        end
        if (accept) begin
            pending_nxt = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_ready) begin
                        state_nxt   = READ;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = WAIT_DEC;
                    end
                end
            end
            WAIT_DEC: begin
                if (dec_ready) begin
                    state_nxt   = READ;
                    pending_nxt = 1'b0;
                end
            end
            READ: begin
                rd_en = 1'b1;
                RA    = count;
                if (count == LAST_ADDR) begin
                    count_nxt = '0;
                    state_nxt = DRAIN;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            // two cycles lets the last read leave both pipeline stages
            DRAIN: begin
                if (count == DRAIN_LAST) begin
                    count_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            pending   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            pending   <= pending_nxt;
            start_err <= err_nxt;
        end
    end

    // stage 1 lines the request up with DOUT_nb; stage 2 issues the write
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_ra  <= '0;
            llr_we <= 1'b0;
            llr_wa <= '0;
            llr_wd <= '0;
        end else begin
            s1_vld <= rd_en;
            s1_ra  <= RA;
            llr_we <= s1_vld;
            if (s1_vld) begin
                llr_wa <= s1_ra;
                llr_wd <= DOUT_nb;
            end
        end
    end

endmodule

// File: tb/tb_infifo_load_ctrl.sv
// Directed bench for infifo_load_ctrl with a one-cycle-latency FIFO model.
module tb_infifo_load_ctrl;

    localparam int W  = 6;
    localparam int AW = 5;
    localparam int NB = 16;
    localparam int DW = 32 * W;
    localparam int LD = 16;
    localparam int WD = NB * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_fsm_start = 1'b0;
    logic          dec_ready = 1'b0;
    logic [WD-1:0] DOUT_nb = '0;
    logic [AW-1:0] RA;
    logic          rd_en;
    logic [AW-1:0] llr_wa;
    logic [WD-1:0] llr_wd;
    logic          llr_we;
    logic          load_busy;
    logic          load_done;
    logic          start_err;

    int n_chk = 0;
    int n_bad = 0;

    infifo_load_ctrl #(
        .W(W), .ADDRESSWIDTH(AW), .NB(NB), .DW(DW), .LOADDEPTH(LD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_fsm_start(load_fsm_start),
        .dec_ready(dec_ready),
        .DOUT_nb(DOUT_nb),
        .RA(RA),
        .rd_en(rd_en),
        .llr_wa(llr_wa),
        .llr_wd(llr_wd),
        .llr_we(llr_we),
        .load_busy(load_busy),
        .load_done(load_done),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WD-1:0] word(input int a);
        logic [WD-1:0] w;
        logic [7:0]    ab;
        logic [7:0]    ib;
        w  = '0;
        ab = a[7:0];
        for (int i = 0; i < WD / 32; i++) begin
            ib = i[7:0];
            w[i*32 +: 32] = {ab ^ ib, 8'hC3, ~ab, ib};
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rd_en) DOUT_nb <= word(int'(RA));
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d: cycles dec_ready is low after the start; es: cycle of a stray start
    task automatic load_seq(input int d, input int es, input int last);
        bit            rd_e;
        bit            we_e;
        bit            err_e;
        logic [WD-1:0] ew;
        for (int t = 0; t <= last; t++) begin
            rst            = 1'b1;
            load_fsm_start = (t == 0) || (es > 0 && t == es);
            dec_ready      = (t >= d) && !(t >= d + 5 && t <= d + 8);
            rd_e  = (t >= 1 + d) && (t <= LD + d);
            we_e  = (t >= 3 + d) && (t <= LD + 2 + d);
            err_e = (es > 0) && (t > es);
            chk("rd_en", 64'(rd_en), 64'(rd_e));
            chk("ra", 64'(RA), rd_e ? 64'(t - 1 - d) : 64'd0);
            chk("llr_we", 64'(llr_we), 64'(we_e));
            chk("busy", 64'(load_busy), 64'((t >= 1) && (t <= LD + 3 + d)));
            chk("done", 64'(load_done), 64'(t == LD + 3 + d));
            chk("err", 64'(start_err), 64'(err_e));
            if (we_e) begin
                ew = word(t - 3 - d);
                chk("wa", 64'(llr_wa), 64'(t - 3 - d));
                chk("wd_lo", llr_wd[63:0], ew[63:0]);
                chk("wd_hi", llr_wd[WD-1 -: 64], ew[WD-1 -: 64]);
                chk("wd_eq", 64'(llr_wd == ew), 64'd1);
            end else if (t > LD + 2 + d) begin
                ew = word(LD - 1);
                chk("wa_hold", 64'(llr_wa), 64'(LD - 1));
                chk("wd_hold", 64'(llr_wd == ew), 64'd1);
            end
            tick();
        end
        load_fsm_start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst            = 1'b0;
            load_fsm_start = 1'($urandom);
            dec_ready      = 1'($urandom);
            tick();
            chk("rst_rd_en", 64'(rd_en), 64'd0);
            chk("rst_ra", 64'(RA), 64'd0);
            chk("rst_we", 64'(llr_we), 64'd0);
            chk("rst_wa", 64'(llr_wa), 64'd0);
            chk("rst_wd", 64'(llr_wd == '0), 64'd1);
            chk("rst_busy", 64'(load_busy), 64'd0);
            chk("rst_done", 64'(load_done), 64'd0);
            chk("rst_err", 64'(start_err), 64'd0);
        end
        rst            = 1'b1;
        load_fsm_start = 1'b0;
        dec_ready      = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        do_reset(5);

        // nominal load
        load_seq(0, 0, 21);

        // decoder busy for 10 cycles after the start
        load_seq(10, 0, 31);

        // stray start in the middle of READ: flagged, ignored, sticky
        load_seq(0, 8, 22);
        for (int i = 0; i < 4; i++) begin
            chk("err_sticky", 64'(start_err), 64'd1);
            chk("no_2nd_rd", 64'(rd_en), 64'd0);
            chk("no_2nd_busy", 64'(load_busy), 64'd0);
            tick();
        end
        do_reset(2);

        // back-to-back: second start on the IDLE cycle right after DONE
        load_seq(0, 0, 19);
        load_seq(0, 0, 22);

        // start during the DONE cycle is an error
        do_reset(2);
        for (int t = 0; t <= 20; t++) begin
            load_fsm_start = (t == 0) || (t == LD + 3);
            dec_ready      = 1'b1;
            tick();
        end
        load_fsm_start = 1'b0;
        chk("done_cyc_err", 64'(start_err), 64'd1);
        chk("done_cyc_idle", 64'(load_busy), 64'd0);
        do_reset(2);

        // reset in the middle of a load
        for (int t = 0; t <= 10; t++) begin
            load_fsm_start = (t == 0);
            dec_ready      = 1'b1;
            if (t == 10) rst = 1'b0;
            tick();
        end
        rst = 1'b1;
        load_fsm_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("mid_rd_en", 64'(rd_en), 64'd0);
            chk("mid_we", 64'(llr_we), 64'd0);
            chk("mid_busy", 64'(load_busy), 64'd0);
            chk("mid_done", 64'(load_done), 64'd0);
            tick();
        end
        load_seq(0, 0, 21);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/infifo_load_ctrl.md
Name: infifo_load_ctrl

Overview:
- Downstream stage of the per-block-column input FIFO. It sits between that FIFO's read side and the decoder's LLR memory.
- On each codeword-complete pulse (load_fsm_start), it sweeps the FIFO read address and drives rd_en.
- It captures the NB-wide read word (NB*DW bits) and forwards it, address-tagged, as write transactions into the decoder LLR memory.
- It handshakes with the decoder so a new codeword is loaded only when the decoder can accept it.

Parameters:
- W, 6: LLR symbol width in bits.
- ADDRESSWIDTH, 5: FIFO read address width.
- NB, 16: block columns, i.e. number of FIFO submemories read in parallel.
- DW, 32*W: width of one submemory word.
- LOADDEPTH, 16: addresses read per codeword (256 write cycles / NB). Must be ≤ 2**ADDRESSWIDTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- load_fsm_start  in  1  one-cycle pulse, clk-synchronous: codeword fully buffered in the FIFO.
- dec_ready  in  1  decoder LLR memory free to accept a codeword.
- DOUT_nb  in  NB*DW  FIFO read data; valid exactly 1 cycle after rd_en.
- RA  out  ADDRESSWIDTH  FIFO read address.
- rd_en  out  1  FIFO read enable.
- llr_wa  out  ADDRESSWIDTH  LLR memory write address.
- llr_wd  out  NB*DW  LLR memory write data.
- llr_we  out  1  LLR memory write enable.
- load_busy  out  1  high from accepted start until load_done.
- load_done  out  1  one-cycle pulse after the last LLR write.
- start_err  out  1  sticky: a start arrived while a previous start was still pending or loading.

Behaviour:
- Reset (rst=0 at posedge) clears all outputs, state, counters and flags. All outputs are 0 after reset; state is IDLE. Reset mid-load aborts immediately; no further rd_en or llr_we is issued.
- Pending flag:
  - Set by load_fsm_start in IDLE or WAIT_DEC.
  - Cleared on the IDLE/WAIT_DEC→READ transition.
  - load_fsm_start while pending is already 1, or while in any state other than IDLE/WAIT_DEC, sets start_err and is otherwise ignored.
  - start_err clears only on reset.
- State IDLE:
  - On load_fsm_start: go to READ if dec_ready=1, else WAIT_DEC.
  - load_busy rises the cycle after the accepted start.
- State WAIT_DEC: hold RA=0, rd_en=0; go to READ on the first cycle dec_ready=1.
- State READ:
  - rd_en=1, RA=count.
  - count goes 0..LOADDEPTH-1, one per cycle, no stalls.
  - At count=LOADDEPTH-1, go to DRAIN and reset count to 0.
  - dec_ready is not re-sampled during READ.
- Write pipeline:
  - rd_en and RA are delayed one cycle to align with DOUT_nb (stage 1), then registered together with DOUT_nb (stage 2).
  - llr_we, llr_wa and llr_wd therefore appear 2 cycles after the corresponding rd_en/RA.
  - llr_wa equals the RA it was read with. llr_wd is DOUT_nb unmodified, bit-for-bit.
- State DRAIN: rd_en=0; wait for the pipeline to empty (2 cycles), then go to DONE.
- State DONE:
  - load_done=1 for one cycle, load_busy drops to 0, go to IDLE.
  - Back-to-back: a load_fsm_start in the DONE cycle is an error (start_err). A start in the IDLE cycle that follows is accepted.
- Timing with dec_ready=1 and start at cycle 0:
  - rd_en high cycles 1..LOADDEPTH.
  - llr_we high cycles 3..LOADDEPTH+2.
  - load_done at cycle LOADDEPTH+3 (19 for defaults).
- Widths:
  - count is ADDRESSWIDTH bits and never wraps past LOADDEPTH-1.
  - RA is held at 0 whenever rd_en=0.
  - llr_wa/llr_wd are held at their last values when llr_we=0.

Test Plan:
- Reset: hold rst=0 with random inputs for 5 cycles → all outputs 0, no rd_en or llr_we.
- Nominal load: dec_ready=1, start pulse at cycle 0, FIFO model returns word=RA pattern → rd_en cycles 1–16 with RA 0..15; llr_we cycles 3–18 with llr_wa 0..15 and llr_wd matching; load_done at cycle 19; load_busy cycles 1–19.
- Decoder not ready: dec_ready=0 for 10 cycles after start, then 1 → RA/rd_en stay 0 during the wait; rd_en begins the cycle after dec_ready rises; 16 reads total, load_done once.
- Overlapping start: second load_fsm_start at cycle 8 of READ → start_err=1 and stays high; that load still completes normally; no second load begins.
- Back-to-back codewords: start at cycle 0, next start at cycle 20 → two complete 16-write sequences; start_err stays 0.
- Reset mid-load: rst=0 at cycle 10 → from cycle 11 rd_en, llr_we, load_busy are 0 and no load_done occurs; a fresh start after release performs a full 16-address load.
